snake_body_tracker: RTL and testbench
=====================================

Name: snake_body_tracker

Overview:
- Sits downstream of the head-position recorder and consumes its motion_x/motion_y head coordinates and edge_collision flag.
- Stores the snake body as a shift history of head positions and grows it on food events.
- Detects self-collision with a serial compare FSM.
- Gives the display/food logic a registered cell-occupancy lookup.

Parameters:
COORD_W, 3, width of each x/y coordinate (8x8 grid)
MAX_LEN, 8, maximum body segments stored (head included)
LEN_W, 4, width of length count, equal to clog2(MAX_LEN+1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
step  input  1  one-cycle pulse: head_x/head_y hold the new head position
head_x  input  COORD_W  new head x (from recorder motion_x)
head_y  input  COORD_W  new head y (from recorder motion_y)
edge_collision  input  1  wall hit from recorder
grow  input  1  one-cycle pulse: food eaten, lengthen on next step
query_x  input  COORD_W  occupancy lookup x
query_y  input  COORD_W  occupancy lookup y
occupied  output  1  registered: (query_x,query_y) matches a live segment
len  output  LEN_W  current live segment count
busy  output  1  step being processed (CHECK or SHIFT)
self_collision  output  1  sticky: new head hit the body
game_over  output  1  high in DEAD state
step_dropped  output  1  sticky: step arrived while busy or dead

Behaviour:
- Reset (async, reset=0):
  - All body[0..MAX_LEN-1] = (0,0); len=1; grow_pend=0.
  - occupied=0, busy=0, self_collision=0, game_over=0, step_dropped=0.
  - State IDLE.
- States: IDLE, CHECK, SHIFT, DEAD.
- IDLE + step:
  - Latch head_x/head_y into new_x/new_y; idx=0.
  - len_eff = len if grow_pend=1 and len<MAX_LEN; otherwise len-1, because the tail vacates its cell.
  - Go to CHECK; busy=1 from the next cycle.
- CHECK, one compare per cycle:
  - If len_eff=0, go straight to SHIFT after 1 cycle.
  - Else if body[idx]==(new_x,new_y): set self_collision=1, go to DEAD.
  - Else if idx==len_eff-1: go to SHIFT.
  - Else idx++.
  - CHECK therefore lasts max(len_eff,1) cycles.
- SHIFT, 1 cycle:
  - body[i]<=body[i-1] for i=1..MAX_LEN-1; body[0]<=(new_x,new_y).
  - If grow_pend and len<MAX_LEN: len<=len+1.
  - grow_pend<=0; go to IDLE. busy drops the cycle after SHIFT.
- Total step latency = max(len_eff,1)+1 cycles from the step-sample edge to return to IDLE.
- grow:
  - Sets grow_pend in any non-DEAD state.
  - Multiple pulses before the next SHIFT count once.
  - A grow arriving in the same cycle as SHIFT remains pending for the following step.
  - At len==MAX_LEN, the grow is consumed without growth.
- edge_collision=1 in any state: go to DEAD next edge. This has priority over step, CHECK, and SHIFT in the same cycle.
- DEAD:
  - game_over=1; body/len frozen.
  - step sets step_dropped.
  - Exit only by reset.
- step while busy: ignored, step_dropped<=1 (sticky).
- occupied: registered every cycle in all states as OR over i<len of (body[i]==(query_x,query_y)). Latency is 1 cycle.
- Entries at index >= len are never compared or reported.

Test Plan:
1. Reset, then hold reset=0 mid-CHECK:
   - Outputs return immediately to len=1, busy=0, game_over=0.
   - Query (0,0) gives occupied=1 one cycle later.
2. step with heads (1,0) then (2,0), no grow:
   - len stays 1; busy high 2 cycles per step.
   - Query (2,0) gives occupied=1; query (1,0) gives occupied=0.
3. grow pulse, then steps (1,0),(2,0),(3,0) with grow before each:
   - len goes 2,3,4.
   - Query (1,0) gives occupied=1; third step busy lasts 4 cycles.
4. Build len=5 along (1,0)..(3,1), then step into a mid-body cell:
   - self_collision=1 and game_over=1 at the end of CHECK.
   - A later step sets step_dropped=1 and len stays 5.
5. len=4 loop, no grow, new head equals the current tail cell:
   - No collision; len stays 4.
   - The old tail position is no longer occupied except as the new head.
6. Two more cases:
   - edge_collision pulse during CHECK: game_over=1 next cycle and len is unchanged.
   - step while busy: step_dropped=1 and the second head is not stored.

Source files
------------

// File: rtl/snake_body_tracker.sv
// rtl/snake_body_tracker.sv - snake body history, serial self-collision check and occupancy lookup
module snake_body_tracker #(
  parameter int COORD_W = 3,
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step,
  input  logic [COORD_W-1:0] head_x,
  input  logic [COORD_W-1:0] head_y,
  input  logic               edge_collision,
  input  logic               grow,
  input  logic [COORD_W-1:0] query_x,
  input  logic [COORD_W-1:0] query_y,
  output logic               occupied,
  output logic [LEN_W-1:0]   len,
  output logic               busy,
  output logic               self_collision,
  output logic               game_over,
  output logic               step_dropped
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CHECK = 2'd1,
    S_SHIFT = 2'd2,
    S_DEAD  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [COORD_W-1:0] body_x_q [MAX_LEN];
  logic [COORD_W-1:0] body_x_d [MAX_LEN];
  logic [COORD_W-1:0] body_y_q [MAX_LEN];
  logic [COORD_W-1:0] body_y_d [MAX_LEN];

  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   len_eff_q, len_eff_d;
  logic [LEN_W-1:0]   idx_q, idx_d;
  logic [COORD_W-1:0] new_x_q, new_x_d;
  logic [COORD_W-1:0] new_y_q, new_y_d;
  logic               grow_pend_q, grow_pend_d;
  logic               occupied_q, occupied_d;
  logic               self_collision_q, self_collision_d;
  logic               step_dropped_q, step_dropped_d;

  logic [COORD_W-1:0] sel_x, sel_y;
  logic               sel_hit;
  logic               sel_last;
  logic               len_eff_zero;
  logic               can_grow;

  // Pick the body entry under compare and derive the CHECK decision terms
  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (idx_q == LEN_W'(i)) begin
        sel_x = body_x_q[i];
        sel_y = body_y_q[i];
      end
    end
    sel_hit      = (sel_x == new_x_q) && (sel_y == new_y_q);
    sel_last     = (idx_q == (len_eff_q - LEN_W'(1)));
    len_eff_zero = (len_eff_q == '0);
    can_grow     = grow_pend_q && (len_q < LEN_W'(MAX_LEN));
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a wall hit overrides everything else in the same cycle
  always_comb begin
    state_d = state_q;
    if (edge_collision) begin
      state_d = S_DEAD;
    end else begin
      case (state_q)
        S_IDLE:  if (step) state_d = S_CHECK;
        S_CHECK: begin
          if (len_eff_zero)  state_d = S_SHIFT;
          else if (sel_hit)  state_d = S_DEAD;
          else if (sel_last) state_d = S_SHIFT;
        end
        S_SHIFT: state_d = S_IDLE;
        default: state_d = S_DEAD;
      endcase
    end
  end

  // Outputs decoded from state and registered status
  always_comb begin
    busy           = (state_q == S_CHECK) || (state_q == S_SHIFT);
    game_over      = (state_q == S_DEAD);
    occupied       = occupied_q;
    len            = len_q;
    self_collision = self_collision_q;
    step_dropped   = step_dropped_q;
  end

  // Datapath next values: head latch, compare index, body shift, growth and status flags
  always_comb begin
    body_x_d         = body_x_q;
    body_y_d         = body_y_q;
    len_d            = len_q;
    len_eff_d        = len_eff_q;
    idx_d            = idx_q;
    new_x_d          = new_x_q;
    new_y_d          = new_y_q;
    grow_pend_d      = grow_pend_q;
    self_collision_d = self_collision_q;
    step_dropped_d   = step_dropped_q;

    occupied_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (body_x_q[i] == query_x) && (body_y_q[i] == query_y)) begin
        occupied_d = 1'b1;
      end
    end

    if (grow && (state_q != S_DEAD)) begin
      grow_pend_d = 1'b1;
    end
    if (step && (state_q != S_IDLE)) begin
      step_dropped_d = 1'b1;
    end

    if (!edge_collision) begin
      case (state_q)
        S_IDLE: begin
          if (step) begin
            new_x_d   = head_x;
            new_y_d   = head_y;
            idx_d     = '0;
            // Without growth the tail leaves its cell, so it is excluded from the compare
            len_eff_d = can_grow ? len_q : (len_q - LEN_W'(1));
          end
        end
        S_CHECK: begin
          if (!len_eff_zero) begin
            if (sel_hit) begin
              self_collision_d = 1'b1;
            end else if (!sel_last) begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
        end
        S_SHIFT: begin
          for (int i = 1; i < MAX_LEN; i++) begin
            body_x_d[i] = body_x_q[i-1];
            body_y_d[i] = body_y_q[i-1];
          end
          body_x_d[0] = new_x_q;
          body_y_d[0] = new_y_q;
          if (can_grow) begin
            len_d = len_q + LEN_W'(1);
          end
          // A grow landing on the shift cycle is kept for the following step
          grow_pend_d = grow;
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        body_x_q[i] <= '0;
        body_y_q[i] <= '0;
      end
      len_q            <= LEN_W'(1);
      len_eff_q        <= '0;
      idx_q            <= '0;
      new_x_q          <= '0;
      new_y_q          <= '0;
      grow_pend_q      <= 1'b0;
      occupied_q       <= 1'b0;
      self_collision_q <= 1'b0;
      step_dropped_q   <= 1'b0;
    end else begin
      body_x_q         <= body_x_d;
      body_y_q         <= body_y_d;
      len_q            <= len_d;
      len_eff_q        <= len_eff_d;
      idx_q            <= idx_d;
      new_x_q          <= new_x_d;
      new_y_q          <= new_y_d;
      grow_pend_q      <= grow_pend_d;
      occupied_q       <= occupied_d;
      self_collision_q <= self_collision_d;
      step_dropped_q   <= step_dropped_d;
    end
  end

endmodule

// File: tb/tb_snake_body_tracker.sv
// tb/tb_snake_body_tracker.sv - randomized self-checking bench for snake_body_tracker
module tb_snake_body_tracker;

  localparam int CW = 3;
  localparam int ML = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          step = 1'b0;
  logic          edge_collision = 1'b0;
  logic          grow = 1'b0;
  logic [CW-1:0] head_x = '0;
  logic [CW-1:0] head_y = '0;
  logic [CW-1:0] query_x = '0;
  logic [CW-1:0] query_y = '0;
  logic          occupied;
  logic [LW-1:0] len;
  logic          busy;
  logic          self_collision;
  logic          game_over;
  logic          step_dropped;

  int total = 0;
  int bad = 0;

  // Reference model: live segments as a queue, head at the front
  int qx[$];
  int qy[$];
  int m_len;
  bit m_pend;
  bit m_dead;
  bit m_self;
  bit m_drop;

  snake_body_tracker #(.COORD_W(CW), .MAX_LEN(ML), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .step(step), .head_x(head_x), .head_y(head_y),
    .edge_collision(edge_collision), .grow(grow), .query_x(query_x), .query_y(query_y),
    .occupied(occupied), .len(len), .busy(busy), .self_collision(self_collision),
    .game_over(game_over), .step_dropped(step_dropped)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_reset();
    qx = {0};
    qy = {0};
    m_len = 1;
    m_pend = 0;
    m_dead = 0;
    m_self = 0;
    m_drop = 0;
  endtask

  task automatic do_reset();
    step = 0;
    grow = 0;
    edge_collision = 0;
    reset = 0;
    tick();
    tick();
    reset = 1;
    m_reset();
  endtask

  function automatic bit m_occ(int x, int y);
    for (int i = 0; i < qx.size(); i++)
      if (qx[i] == x && qy[i] == y) return 1'b1;
    return 1'b0;
  endfunction

  // Expected step outcome from the game rules: cycles busy and whether the head bites the body
  task automatic m_expect(input int x, input int y, output int exp, output bit hit);
    int le;
    int k;
    le = (m_pend && m_len < ML) ? m_len : m_len - 1;
    hit = 0;
    k = 0;
    for (int i = 0; i < le; i++)
      if (!hit && qx[i] == x && qy[i] == y) begin
        hit = 1;
        k = i;
      end
    exp = hit ? k + 1 : ((le == 0) ? 1 : le) + 1;
  endtask

  task automatic m_apply(input int x, input int y, input bit hit);
    if (hit) begin
      m_dead = 1;
      m_self = 1;
    end else begin
      qx.push_front(x);
      qy.push_front(y);
      if (m_pend && m_len < ML) m_len++;
      m_pend = 0;
      while (qx.size() > m_len) begin
        void'(qx.pop_back());
        void'(qy.pop_back());
      end
    end
  endtask

  task automatic do_step(input int x, input int y, output int got, output int exp);
    bit hit;
    m_expect(x, y, exp, hit);
    head_x = CW'(x);
    head_y = CW'(y);
    step = 1;
    tick();
    step = 0;
    got = 0;
    while (busy === 1'b1 && got < 40) begin
      got++;
      tick();
    end
    m_apply(x, y, hit);
  endtask

  task automatic do_grow();
    grow = 1;
    tick();
    grow = 0;
    if (!m_dead) m_pend = 1;
  endtask

  task automatic query(input int x, input int y, output bit o);
    query_x = CW'(x);
    query_y = CW'(y);
    tick();
    o = occupied;
  endtask

  task automatic grow_step(input int x, input int y);
    int g;
    int e;
    do_grow();
    do_step(x, y, g, e);
  endtask

  task automatic test_reset();
    bit o;
    do_reset();
    total++; if (len !== LW'(1)) begin bad++; $display("FAIL reset_len got=%0d want=1", len); end
    total++; if (busy !== 1'b0 || game_over !== 1'b0) begin bad++; $display("FAIL reset_busy_dead got=%b%b want=00", busy, game_over); end
    total++; if (self_collision !== 1'b0 || step_dropped !== 1'b0) begin bad++; $display("FAIL reset_sticky got=%b%b want=00", self_collision, step_dropped); end
    query(0, 0, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL reset_occ00 got=%b want=1", o); end
    query(3, 5, o);
    total++; if (o !== 1'b0) begin bad++; $display("FAIL reset_occ35 got=%b want=0", o); end
    grow_step(1, 0);
    grow_step(2, 0);
    head_x = 3'd5;
    head_y = 3'd5;
    step = 1;
    tick();
    step = 0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL midcheck_busy got=%b want=1", busy); end
    #2 reset = 0;
    #1;
    total++; if (len !== LW'(1) || busy !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL midcheck_reset got len=%0d busy=%b dead=%b want 1 0 0", len, busy, game_over);
    end
    tick();
    reset = 1;
    m_reset();
    query(0, 0, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL midcheck_occ00 got=%b want=1", o); end
  endtask

  task automatic test_basic();
    int got;
    int exp;
    bit o;
    do_reset();
    do_step(1, 0, got, exp);
    total++; if (got !== exp || exp !== 2) begin bad++; $display("FAIL basic_lat1 got=%0d want=%0d", got, exp); end
    do_step(2, 0, got, exp);
    total++; if (got !== exp) begin bad++; $display("FAIL basic_lat2 got=%0d want=%0d", got, exp); end
    total++; if (len !== LW'(1)) begin bad++; $display("FAIL basic_len got=%0d want=1", len); end
    query(2, 0, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL basic_occ20 got=%b want=1", o); end
    query(1, 0, o);
    total++; if (o !== 1'b0) begin bad++; $display("FAIL basic_occ10 got=%b want=0", o); end
  endtask

  task automatic test_grow();
    int got;
    int exp;
    bit o;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      do_grow();
      do_step(i, 0, got, exp);
      total++; if (len !== LW'(i + 1)) begin bad++; $display("FAIL grow_len%0d got=%0d want=%0d", i, len, i + 1); end
      total++; if (got !== exp) begin bad++; $display("FAIL grow_lat%0d got=%0d want=%0d", i, got, exp); end
    end
    total++; if (got !== 4) begin bad++; $display("FAIL grow_lat_third got=%0d want=4", got); end
    query(1, 0, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL grow_occ10 got=%b want=1", o); end
  endtask

  task automatic test_self_collision();
    int got;
    int exp;
    grow_step(0, 0);
    do_reset();
    grow_step(1, 0);
    grow_step(2, 0);
    grow_step(3, 0);
    grow_step(3, 1);
    total++; if (len !== LW'(5)) begin bad++; $display("FAIL bite_setup_len got=%0d want=5", len); end
    do_step(2, 0, got, exp);
    total++; if (got !== exp || exp !== 3) begin bad++; $display("FAIL bite_lat got=%0d want=%0d", got, exp); end
    total++; if (self_collision !== 1'b1 || game_over !== 1'b1) begin
      bad++; $display("FAIL bite_flags got=%b%b want=11", self_collision, game_over);
    end
    head_x = 3'd4;
    head_y = 3'd4;
    step = 1;
    tick();
    step = 0;
    tick();
    total++; if (step_dropped !== 1'b1) begin bad++; $display("FAIL bite_drop got=%b want=1", step_dropped); end
    total++; if (len !== LW'(5) || game_over !== 1'b1) begin bad++; $display("FAIL bite_frozen got len=%0d dead=%b want 5 1", len, game_over); end
  endtask

  task automatic test_tail();
    int got;
    int exp;
    int nbad;
    bit o;
    do_reset();
    grow_step(1, 0);
    grow_step(1, 1);
    grow_step(0, 1);
    do_step(0, 0, got, exp);
    total++; if (self_collision !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL tail_nocoll got=%b%b want=00", self_collision, game_over);
    end
    total++; if (len !== LW'(4) || got !== exp) begin bad++; $display("FAIL tail_len_lat got=%0d/%0d want=4/%0d", len, got, exp); end
    nbad = 0;
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++) begin
        query(x, y, o);
        if (o !== m_occ(x, y)) nbad++;
      end
    total++; if (nbad !== 0) begin bad++; $display("FAIL tail_occ_map got=%0d wrong cells want=0", nbad); end
  endtask

  task automatic test_maxlen();
    int got;
    int exp;
    int px[10] = '{1, 2, 3, 4, 5, 6, 7, 7, 7, 7};
    int py[10] = '{0, 0, 0, 0, 0, 0, 0, 1, 2, 3};
    do_reset();
    for (int i = 0; i < 9; i++) grow_step(px[i], py[i]);
    total++; if (len !== LW'(8)) begin bad++; $display("FAIL max_len got=%0d want=8", len); end
    do_step(px[9], py[9], got, exp);
    total++; if (len !== LW'(8) || got !== exp || exp !== 8) begin
      bad++; $display("FAIL max_noext got len=%0d lat=%0d want 8 %0d", len, got, exp);
    end
  endtask

  task automatic test_edge();
    bit o;
    do_reset();
    grow_step(1, 0);
    grow_step(2, 0);
    head_x = 3'd5;
    head_y = 3'd5;
    step = 1;
    tick();
    step = 0;
    edge_collision = 1;
    tick();
    edge_collision = 0;
    m_dead = 1;
    total++; if (game_over !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL edge_dead got dead=%b busy=%b want 1 0", game_over, busy); end
    total++; if (len !== LW'(3) || self_collision !== 1'b0) begin bad++; $display("FAIL edge_len got len=%0d sc=%b want 3 0", len, self_collision); end
    query(5, 5, o);
    total++; if (o !== 1'b0) begin bad++; $display("FAIL edge_occ55 got=%b want=0", o); end
    query(2, 0, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL edge_occ20 got=%b want=1", o); end
  endtask

  task automatic test_back_to_back();
    int n;
    int exp;
    bit hit;
    bit o;
    do_reset();
    grow_step(1, 0);
    grow_step(2, 0);
    m_expect(5, 5, exp, hit);
    head_x = 3'd5;
    head_y = 3'd5;
    step = 1;
    tick();
    head_x = 3'd6;
    head_y = 3'd6;
    tick();
    step = 0;
    n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      tick();
    end
    m_apply(5, 5, hit);
    total++; if (step_dropped !== 1'b1) begin bad++; $display("FAIL b2b_drop got=%b want=1", step_dropped); end
    total++; if (n + 1 !== exp) begin bad++; $display("FAIL b2b_lat got=%0d want=%0d", n + 1, exp); end
    query(6, 6, o);
    total++; if (o !== 1'b0) begin bad++; $display("FAIL b2b_occ66 got=%b want=0", o); end
    query(5, 5, o);
    total++; if (o !== 1'b1) begin bad++; $display("FAIL b2b_occ55 got=%b want=1", o); end
  endtask

  task automatic test_random();
    int got;
    int exp;
    int x;
    int y;
    bit o;
    do_reset();
    for (int it = 0; it < 80; it++) begin
      if (m_dead) do_reset();
      if ($urandom_range(0, 2) != 0) do_grow();
      x = int'($urandom_range(0, 7));
      y = int'($urandom_range(0, 7));
      do_step(x, y, got, exp);
      total++; if (got !== exp) begin bad++; $display("FAIL rnd_lat it=%0d got=%0d want=%0d", it, got, exp); end
      total++; if (len !== LW'(m_len) || game_over !== m_dead || self_collision !== m_self) begin
        bad++; $display("FAIL rnd_state it=%0d got len=%0d dead=%b sc=%b want %0d %b %b", it, len, game_over, self_collision, m_len, m_dead, m_self);
      end
      x = int'($urandom_range(0, 7));
      y = int'($urandom_range(0, 7));
      query(x, y, o);
      total++; if (o !== m_occ(x, y)) begin bad++; $display("FAIL rnd_occ it=%0d (%0d,%0d) got=%b want=%b", it, x, y, o, m_occ(x, y)); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_grow();
    test_self_collision();
    test_tail();
    test_maxlen();
    test_edge();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
